stream_fifo: RTL

//  - Synthesizable val/rdy message queue; decouples a producer from a consumer stream.
//  - Upstream port is the DUT side of an istream; downstream port drives an ostream.
//  - The downstream port feeds the FL output-stream sink directly in unit benches.
//  - Absorbs sink delay (p_delay) without back-pressuring the producer until full.
//

---
 rtl/stream_fifo_pkg.sv | 18 +
 rtl/stream_fifo_ctrl.sv | 87 ++++++++
 rtl/stream_fifo.sv | 88 ++++++++
 3 files changed

// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_pkg
// Description : Shared constants and elaboration helpers for stream_fifo.
// Revision    : 1.0 - initial release
// ============================================================================

package stream_fifo_pkg;

    localparam int c_DEFAULT_DEPTH = 4;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_ctrl
// Description : Pointer/occupancy bookkeeping and handshake for stream_fifo.
// Revision    : 1.0 - initial release
// ============================================================================

module stream_fifo_ctrl
    import stream_fifo_pkg::*;
#(
    parameter  int p_depth = c_DEFAULT_DEPTH,
    localparam int c_PTR_W = $clog2(p_depth),
    localparam int c_CNT_W = $clog2(p_depth + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_val,
    input  logic               deq_rdy,
    input  logic               bypass_take,
    output logic               enq_rdy,
    output logic               deq_val,
    output logic               wr_en,
    output logic [c_PTR_W-1:0] wr_ptr,
    output logic [c_PTR_W-1:0] rd_ptr,
    output logic [c_CNT_W-1:0] count
);

    logic               r_live;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_rd_en;

    // Holds enq_rdy low during reset and for the cycle in which reset releases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_full  = (r_count == c_CNT_W'(p_depth));
    assign w_empty = (r_count == '0);

    assign enq_rdy = r_live && !w_full;
    assign deq_val = !w_empty;
    assign wr_en   = enq_val && enq_rdy && !bypass_take;
    assign w_rd_en = deq_val && deq_rdy;

    // Depth is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign wr_ptr = r_wr_ptr;
    assign rd_ptr = r_rd_ptr;
    assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : val/rdy message queue with registered storage and
//               combinational read. Optional empty-queue bypass is enabled
//               by defining STREAM_FIFO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter  type t_msg   = logic [31:0],
    parameter  int  p_depth = c_DEFAULT_DEPTH,
    localparam int  c_PTR_W = $clog2(p_depth),
    localparam int  c_CNT_W = $clog2(p_depth + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  t_msg               enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output t_msg               deq_msg,
    output logic [c_CNT_W-1:0] count
);

    if (!is_pow2(p_depth) || (p_depth < 2)) begin : g_bad_depth
        $error("stream_fifo: p_depth must be a power of two and at least 2");
    end

    t_msg               r_mem [p_depth];

    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [c_CNT_W-1:0] w_count;
    logic               w_enq_rdy;
    logic               w_stored_val;
    logic               w_bypass_take;
    t_msg               w_stored_msg;

    stream_fifo_ctrl #(
        .p_depth     (p_depth)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .enq_val     (enq_val),
        .deq_rdy     (deq_rdy),
        .bypass_take (w_bypass_take),
        .enq_rdy     (w_enq_rdy),
        .deq_val     (w_stored_val),
        .wr_en       (w_wr_en),
        .wr_ptr      (w_wr_ptr),
        .rd_ptr      (w_rd_ptr),
        .count       (w_count)
    );

    // Storage is deliberately unreset; deq_msg is only meaningful with deq_val.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_ptr] <= enq_msg;
        end
    end

    assign w_stored_msg = r_mem[w_rd_ptr];

`ifdef STREAM_FIFO_BYPASS_EN
    logic w_byp_active;

    // Gated by enq_rdy so nothing leaks through while reset is in effect.
    assign w_byp_active  = (w_count == '0) && w_enq_rdy;
    assign w_bypass_take = w_byp_active && enq_val && deq_rdy;
    assign deq_val       = w_byp_active ? enq_val : w_stored_val;
    assign deq_msg       = w_byp_active ? enq_msg : w_stored_msg;
`else
    assign w_bypass_take = 1'b0;
    assign deq_val       = w_stored_val;
    assign deq_msg       = w_stored_msg;
`endif

    assign enq_rdy = w_enq_rdy;
    assign count   = w_count;

endmodule

`default_nettype wire
